rgmii_rx_ctrl: RTL and testbench

Receive-side sequencer for the RGMII input path built from IDDR primitives. It releases the IDDR reset after a settle period and assembles IDDR nibble pairs into bytes. It strips preamble and SFD, then emits a framed byte stream with start/end/error markers to the UDP receive logic. It also keeps frame, drop and error statistics.

---
 rtl/rgmii_rx_ctrl.sv | 251 +++++++++++++++++++++++++
 tb/tb_rgmii_rx_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/rgmii_rx_ctrl.sv
// RGMII receive sequencer: IDDR reset release, preamble/SFD strip, byte framing and statistics.
// Defining RGMII_INBAND_STATUS_EN adds in-band link status decode between frames.
module rgmii_rx_ctrl #(
  parameter int IDDR_RST_CYCLES = 16,
  parameter int MAX_FRAME_LEN   = 1518,
  parameter int MAX_PREAMBLE    = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        iddr_rst,
  input  logic [3:0]  rxd_q0,
  input  logic [3:0]  rxd_q1,
  input  logic        rxctl_q0,
  input  logic        rxctl_q1,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_sof,
  output logic        out_eof,
  output logic        out_err,
  output logic [15:0] frame_cnt,
  output logic [15:0] drop_cnt,
  output logic [15:0] err_cnt,
  output logic        link_up,
  output logic [1:0]  speed,
  output logic        full_duplex
);

  localparam int            CW         = $clog2(MAX_FRAME_LEN + 1);
  localparam logic [7:0]    RST_LAST_C = 8'(IDDR_RST_CYCLES - 1);
  localparam logic [7:0]    MAX_PRE_C  = 8'(MAX_PREAMBLE);
  localparam logic [CW-1:0] MAX_LEN_C  = CW'(MAX_FRAME_LEN);
  localparam logic [7:0]    PRE_BYTE_C = 8'h55;
  localparam logic [7:0]    SFD_BYTE_C = 8'hD5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    DROP = 2'd3
  } state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic          iddr_rst_r;
  logic [7:0]    rst_cnt_r;
  logic          dv_r, er_r;
  logic [7:0]    byte_r;
  state_t        state_r, state_s;
  logic [7:0]    pcnt_r, pcnt_s;
  logic [CW-1:0] bcnt_r, bcnt_s;
  logic [7:0]    hold_r, hold_s;
  logic          bad_r, bad_s;
  logic [7:0]    data_r, data_s;
  logic          valid_r, valid_s, sof_r, sof_s, eof_r, eof_s, err_r, err_s;
  logic          inc_frame_s, inc_drop_s, inc_err_s;
  logic [15:0]   frame_cnt_r, drop_cnt_r, err_cnt_r;

  // IDDR reset settle counter: one-shot release after rst_n deasserts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iddr_rst_r <= 1'b1;
      rst_cnt_r  <= 8'd0;
    end else if (iddr_rst_r) begin
      if (rst_cnt_r == RST_LAST_C) iddr_rst_r <= 1'b0;
      else                         rst_cnt_r  <= rst_cnt_r + 8'd1;
    end
  end

  // input capture, masked while the IDDRs are still in reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_r   <= 1'b0;
      er_r   <= 1'b0;
      byte_r <= 8'd0;
    end else begin
      dv_r   <= rxctl_q0 & ~iddr_rst_r;
      er_r   <= (rxctl_q0 ^ rxctl_q1) & ~iddr_rst_r;
      byte_r <= iddr_rst_r ? 8'd0 : {rxd_q1, rxd_q0};
    end
  end

  // next-state, holding register and output beat decode
  always_comb begin
    state_s     = state_r;
    pcnt_s      = pcnt_r;
    bcnt_s      = bcnt_r;
    hold_s      = hold_r;
    bad_s       = bad_r;
    data_s      = 8'd0;
    valid_s     = 1'b0;
    sof_s       = 1'b0;
    eof_s       = 1'b0;
    err_s       = 1'b0;
    inc_frame_s = 1'b0;
    inc_drop_s  = 1'b0;
    inc_err_s   = 1'b0;
    if (iddr_rst_r) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (!dv_r) begin
            state_s = IDLE;
          end else if (byte_r == PRE_BYTE_C) begin
            state_s = PRE;
            pcnt_s  = 8'd1;
          end else if (byte_r == SFD_BYTE_C) begin
            state_s = DATA;
            bcnt_s  = '0;
            bad_s   = 1'b0;
          end else begin
            state_s    = DROP;
            inc_drop_s = 1'b1;
          end
        end
        PRE: begin
          if (!dv_r) begin
            state_s    = IDLE;
            inc_drop_s = 1'b1;
          end else if (er_r) begin
            state_s    = DROP;
            inc_drop_s = 1'b1;
          end else if (byte_r == PRE_BYTE_C && pcnt_r < MAX_PRE_C) begin
            pcnt_s = pcnt_r + 8'd1;
          end else if (byte_r == SFD_BYTE_C) begin
            state_s = DATA;
            bcnt_s  = '0;
            bad_s   = 1'b0;
          end else begin
            state_s    = DROP;
            inc_drop_s = 1'b1;
          end
        end
        DATA: begin
          // the held byte is only known to be last once dv falls or the limit is hit
          if (!dv_r) begin
            state_s = IDLE;
            if (bcnt_r == '0) begin
              inc_drop_s = 1'b1;
            end else begin
              valid_s     = 1'b1;
              data_s      = hold_r;
              sof_s       = (bcnt_r == CW'(1));
              eof_s       = 1'b1;
              err_s       = bad_r;
              inc_err_s   = bad_r;
              inc_frame_s = ~bad_r;
            end
          end else if (bcnt_r == MAX_LEN_C) begin
            state_s   = DROP;
            valid_s   = 1'b1;
            data_s    = hold_r;
            sof_s     = (bcnt_r == CW'(1));
            eof_s     = 1'b1;
            err_s     = 1'b1;
            inc_err_s = 1'b1;
          end else begin
            hold_s = byte_r;
            bcnt_s = bcnt_r + CW'(1);
            bad_s  = bad_r | er_r;
            if (bcnt_r != '0) begin
              valid_s = 1'b1;
              data_s  = hold_r;
              sof_s   = (bcnt_r == CW'(1));
            end else begin
              valid_s = 1'b0;
            end
          end
        end
        DROP: begin
          if (!dv_r) state_s = IDLE;
          else       state_s = DROP;
        end
        default: state_s = IDLE;
      endcase
    end
  end

  // FSM state, registered output beat and saturating statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      pcnt_r      <= 8'd0;
      bcnt_r      <= '0;
      hold_r      <= 8'd0;
      bad_r       <= 1'b0;
      data_r      <= 8'd0;
      valid_r     <= 1'b0;
      sof_r       <= 1'b0;
      eof_r       <= 1'b0;
      err_r       <= 1'b0;
      frame_cnt_r <= 16'd0;
      drop_cnt_r  <= 16'd0;
      err_cnt_r   <= 16'd0;
    end else begin
      state_r <= state_s;
      pcnt_r  <= pcnt_s;
      bcnt_r  <= bcnt_s;
      hold_r  <= hold_s;
      bad_r   <= bad_s;
      data_r  <= data_s;
      valid_r <= valid_s;
      sof_r   <= sof_s;
      eof_r   <= eof_s;
      err_r   <= err_s;
      if (inc_frame_s) frame_cnt_r <= sat_inc(frame_cnt_r);
      if (inc_drop_s)  drop_cnt_r  <= sat_inc(drop_cnt_r);
      if (inc_err_s)   err_cnt_r   <= sat_inc(err_cnt_r);
    end
  end

  assign iddr_rst  = iddr_rst_r;
  assign out_data  = data_r;
  assign out_valid = valid_r;
  assign out_sof   = sof_r;
  assign out_eof   = eof_r;
  assign out_err   = err_r;
  assign frame_cnt = frame_cnt_r;
  assign drop_cnt  = drop_cnt_r;
  assign err_cnt   = err_cnt_r;

`ifdef RGMII_INBAND_STATUS_EN
  logic       link_up_r;
  logic [1:0] speed_r;
  logic       full_duplex_r;

  // in-band status is only meaningful on an idle, error-free line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_up_r     <= 1'b0;
      speed_r       <= 2'd0;
      full_duplex_r <= 1'b0;
    end else if (state_r == IDLE && !dv_r && !er_r && !iddr_rst_r) begin
      link_up_r     <= byte_r[0];
      speed_r       <= byte_r[2:1];
      full_duplex_r <= byte_r[3];
    end
  end

  assign link_up     = link_up_r;
  assign speed       = speed_r;
  assign full_duplex = full_duplex_r;
`else
  assign link_up     = 1'b0;
  assign speed       = 2'd0;
  assign full_duplex = 1'b0;
`endif

endmodule

// File: tb/tb_rgmii_rx_ctrl.sv
// Scoreboard bench for rgmii_rx_ctrl: expected beats queued as bytes are driven, popped on out_valid.
module tb_rgmii_rx_ctrl;

  localparam int MAX_LEN = 1518;
  localparam int MAX_PRE = 7;
  localparam int LAT     = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iddr_rst;
  logic [3:0]  rxd_q0 = 4'd0, rxd_q1 = 4'd0;
  logic        rxctl_q0 = 1'b0, rxctl_q1 = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid, out_sof, out_eof, out_err;
  logic [15:0] frame_cnt, drop_cnt, err_cnt;
  logic        link_up, full_duplex;
  logic [1:0]  speed;

  rgmii_rx_ctrl dut (
    .clk(clk), .rst_n(rst_n), .iddr_rst(iddr_rst),
    .rxd_q0(rxd_q0), .rxd_q1(rxd_q1), .rxctl_q0(rxctl_q0), .rxctl_q1(rxctl_q1),
    .out_data(out_data), .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof),
    .out_err(out_err), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt), .err_cnt(err_cnt),
    .link_up(link_up), .speed(speed), .full_duplex(full_duplex)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       sof, eof, err;
    int         cyc;
  } beat_t;

  beat_t sb[$];
  int    cyc = 0;
  int    n_cmp = 0, n_bad = 0;
  int    exp_frame = 0, exp_drop = 0, exp_err = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic dv, input logic er, input logic [7:0] b);
    @(posedge clk);
    #1;
    rxd_q0   = b[3:0];
    rxd_q1   = b[7:4];
    rxctl_q0 = dv;
    rxctl_q1 = dv ^ er;
  endtask

  task automatic push(input logic [7:0] d, input logic sof, input logic eof, input logic err);
    beat_t e;
    e.d = d; e.sof = sof; e.eof = eof; e.err = err; e.cyc = cyc;
    sb.push_back(e);
  endtask

  // preamble + SFD + len bytes (base+i), optional er on byte er_idx, then one idle cycle
  task automatic frame(input int npre, input int len, input logic [7:0] base, input int er_idx);
    logic       drop;
    logic       bad;
    int         n_emit;
    logic [7:0] b;
    drop   = (npre > MAX_PRE);
    n_emit = (len > MAX_LEN) ? MAX_LEN : len;
    bad    = (len > MAX_LEN) || (er_idx >= 0 && er_idx < len);
    for (int p = 0; p < npre; p++) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < len; i++) begin
      b = 8'(base + 8'(i));
      drive(1'b1, i == er_idx, b);
      if (!drop && i < n_emit) push(b, i == 0, i == n_emit - 1, (i == n_emit - 1) && bad);
    end
    drive(1'b0, 1'b0, 8'h00);
    if (drop || len == 0) exp_drop++;
    else if (bad)         exp_err++;
    else                  exp_frame++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic check_cnts(input string tag);
    chk({tag, ".frame_cnt"}, 32'(frame_cnt), 32'(exp_frame));
    chk({tag, ".drop_cnt"},  32'(drop_cnt),  32'(exp_drop));
    chk({tag, ".err_cnt"},   32'(err_cnt),   32'(exp_err));
    chk({tag, ".sb_left"},   32'(sb.size()), 32'd0);
  endtask

  // output monitor: every beat must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        beat_t e;
        e = sb.pop_front();
        chk("data", 32'(out_data), 32'(e.d));
        chk("sof",  32'(out_sof),  32'(e.sof));
        chk("eof",  32'(out_eof),  32'(e.eof));
        if (out_eof) chk("err", 32'(out_err), 32'(e.err));
        chk("latency", 32'(cyc - e.cyc), 32'(LAT));
      end
    end
  end

  initial begin
    #200000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.iddr_rst", 32'(iddr_rst), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_data", 32'(out_data), 32'd0);
    chk("rst.link_up", 32'(link_up), 32'd0);
    check_cnts("rst");

    // settle window with line activity that must be ignored
    rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      n++;
      if (!iddr_rst) break;
      rxctl_q0 = (k < 12);
      rxctl_q1 = (k < 12);
      rxd_q0   = (k % 2 == 1) ? 4'h5 : 4'h5;
      rxd_q1   = (k % 2 == 1) ? 4'hD : 4'h5;
    end
    chk("iddr_rst_len", 32'(n), 32'd16);
    idle(5);
    check_cnts("settle");

    frame(7, 64, 8'h01, -1);
    idle(4);
    check_cnts("good64");

    frame(7, 64, 8'h01, 9);
    idle(4);
    check_cnts("er64");

    drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'h12);
    drive(1'b0, 1'b0, 8'h00);
    exp_drop++;
    idle(3);
    check_cnts("bad_pre");
    frame(7, 1, 8'hAA, -1);
    idle(4);
    check_cnts("one_byte");

    frame(7, 1600, 8'h00, -1);
    frame(3, 5, 8'h80, -1);
    idle(4);
    check_cnts("trunc");

    frame(2, 0, 8'h00, -1);
    frame(8, 4, 8'h20, -1);
    frame(0, 3, 8'hC0, -1);
    frame(1, 2, 8'hE0, -1);
    idle(4);
    check_cnts("misc");

    // reset in the middle of a frame
    for (int p = 0; p < 7; p++) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 8'(8'h30 + 8'(i)));
      if (i < 2) push(8'(8'h30 + 8'(i)), i == 0, 1'b0, 1'b0);
    end
    @(posedge clk);
    #1;
    chk("pre_rst.out_valid", 32'(out_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    rxctl_q0 = 1'b0;
    rxctl_q1 = 1'b0;
    #1;
    exp_frame = 0; exp_drop = 0; exp_err = 0;
    chk("mid_rst.out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst.iddr_rst", 32'(iddr_rst), 32'd1);
    check_cnts("mid_rst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(20);
    chk("post_rst.iddr_rst", 32'(iddr_rst), 32'd0);
    frame(7, 16, 8'h90, -1);
    idle(4);
    check_cnts("post_rst");

    // in-band status on idle line
    idle(1);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 8'h0D);
`ifdef RGMII_INBAND_STATUS_EN
    chk("inband.link_up", 32'(link_up), 32'd1);
    chk("inband.speed", 32'(speed), 32'd2);
    chk("inband.full_duplex", 32'(full_duplex), 32'd1);
`else
    chk("inband.link_up", 32'(link_up), 32'd0);
    chk("inband.speed", 32'(speed), 32'd0);
    chk("inband.full_duplex", 32'(full_duplex), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
